instr_controller: RTL and testbench

- Upstream control stage for the datapath.
- Holds the 16-bit instruction register and decodes the instruction fields.
- Sequences each instruction with a Moore FSM that drives every datapath control and immediate input: readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, sximm5, sximm8.
- Start/wait handshake with the surrounding CPU: s starts an instruction, w reports idle.

---
 rtl/instr_controller_if.sv | 36 +++
 rtl/instr_controller.sv | 195 +++++++++++++++++++
 tb/tb_instr_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/instr_controller_if.sv
// Instruction-controller bus: IR load/start handshake from the CPU and the
// full set of datapath control and immediate outputs.
interface instr_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    // Surrounding CPU side: supplies instructions and start, consumes controls
    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm5, sximm8
    );

    // Controller side
    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm5, sximm8
    );
endinterface

// File: rtl/instr_controller.sv
// Instruction controller: owns the 16-bit IR, decodes its fields and steps a
// Moore FSM that drives every datapath control. Control outputs are registered
// decodes of the state being entered; only the immediates, shift and ALUop
// follow the IR combinationally.
module instr_controller (
    input  logic              clk,
    input  logic              reset,
    instr_controller_if.slave bus
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_GETA     = 3'd2,
        ST_GETB     = 3'd3,
        ST_EXEC     = 3'd4,
        ST_WRITE    = 3'd5,
        ST_WRITEIMM = 3'd6
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
    } ctrl_t;

    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [1:0] OP_MOVREG  = 2'b00;
    localparam logic [1:0] OP_MOVIMM  = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    // Instruction class helpers, all keyed on opcode/op of a given IR value
    function automatic logic is_mov_imm(input logic [15:0] ir);
        return (ir[15:13] == OPC_MOV) && (ir[12:11] == OP_MOVIMM);
    endfunction

    function automatic logic is_mov_reg(input logic [15:0] ir);
        return (ir[15:13] == OPC_MOV) && (ir[12:11] == OP_MOVREG);
    endfunction

    function automatic logic is_mvn(input logic [15:0] ir);
        return (ir[15:13] == OPC_ALU) && (ir[12:11] == OP_MVN);
    endfunction

    function automatic logic is_cmp(input logic [15:0] ir);
        return (ir[15:13] == OPC_ALU) && (ir[12:11] == OP_CMP);
    endfunction

    // Two-operand ALU ops (ADD, CMP, AND) need Rn fetched into A first
    function automatic logic is_two_src(input logic [15:0] ir);
        return (ir[15:13] == OPC_ALU) && (ir[12:11] != OP_MVN);
    endfunction

    // Next-state rule of the sequencer; s only matters in WAIT
    function automatic state_t next_state_f(input state_t st, input logic start,
                                            input logic [15:0] ir);
        state_t nxt;
        nxt = ST_WAIT;
        case (st)
            ST_WAIT: begin
                if (start) nxt = ST_DECODE;
                else       nxt = ST_WAIT;
            end
            ST_DECODE: begin
                if (is_mov_imm(ir))                  nxt = ST_WRITEIMM;
                else if (is_mov_reg(ir) || is_mvn(ir)) nxt = ST_GETB;
                else if (is_two_src(ir))             nxt = ST_GETA;
                else                                 nxt = ST_WAIT;
            end
            ST_GETA:     nxt = ST_GETB;
            ST_GETB:     nxt = ST_EXEC;
            ST_EXEC: begin
                if (is_cmp(ir)) nxt = ST_WAIT;
                else            nxt = ST_WRITE;
            end
            ST_WRITE:    nxt = ST_WAIT;
            ST_WRITEIMM: nxt = ST_WAIT;
            default:     nxt = ST_WAIT;
        endcase
        return nxt;
    endfunction

    // Moore output decode for a state, given the IR that is held in that state
    function automatic ctrl_t ctrl_f(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            ST_WAIT: begin
                c.w = 1'b1;
            end
            ST_DECODE: begin
                c.w = 1'b0;
            end
            ST_WRITEIMM: begin
                c.writenum = ir[10:8];
                c.vsel     = VSEL_IMM8;
                c.write    = 1'b1;
            end
            ST_GETA: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            ST_GETB: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            ST_EXEC: begin
                c.asel = is_mov_reg(ir);
                c.bsel = 1'b0;
                if (is_cmp(ir)) begin
                    c.loads = 1'b1;
                    c.loadc = 1'b0;
                end else begin
                    c.loads = 1'b0;
                    c.loadc = 1'b1;
                end
            end
            ST_WRITE: begin
                c.writenum = ir[7:5];
                c.vsel     = VSEL_C;
                c.write    = 1'b1;
            end
            default: begin
                c.w = 1'b1;
            end
        endcase
        return c;
    endfunction

    state_t      r_state;
    logic [15:0] r_ir;
    ctrl_t       r_ctrl;

    state_t      w_next_state;
    logic [15:0] w_ir_next;
    logic        w_ir_capture;

    // IR may only change while idle, so decode stays stable for a whole instruction
    always_comb begin
        w_ir_capture = (r_state == ST_WAIT) && bus.load;
        if (w_ir_capture) w_ir_next = bus.in;
        else              w_ir_next = r_ir;
        w_next_state = next_state_f(r_state, bus.s, r_ir);
    end

    // Sequencer: state, IR and the registered controls for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_ir    <= 16'h0000;
            r_ctrl  <= ctrl_f(ST_WAIT, 16'h0000);
        end else begin
            r_state <= w_next_state;
            r_ir    <= w_ir_next;
            r_ctrl  <= ctrl_f(w_next_state, w_ir_next);
        end
    end

    // Drive the bus: strobes are gated by reset so nothing commits while it is held
    always_comb begin
        bus.w        = r_ctrl.w;
        bus.readnum  = r_ctrl.readnum;
        bus.writenum = r_ctrl.writenum;
        bus.asel     = r_ctrl.asel;
        bus.bsel     = r_ctrl.bsel;
        bus.vsel     = r_ctrl.vsel;
        bus.write    = r_ctrl.write & ~reset;
        bus.loada    = r_ctrl.loada & ~reset;
        bus.loadb    = r_ctrl.loadb & ~reset;
        bus.loadc    = r_ctrl.loadc & ~reset;
        bus.loads    = r_ctrl.loads & ~reset;
    end

    // Field decode that tracks IR directly
    always_comb begin
        bus.sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
        bus.sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
        bus.shift  = r_ir[4:3];
        if (r_ir[15:13] == OPC_ALU) bus.ALUop = r_ir[12:11];
        else                        bus.ALUop = 2'b00;
    end

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller: walks each instruction class state by
// state with hand-computed expected controls.
module tb_instr_controller;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    instr_controller_if bus ();

    instr_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ctrl(input string tag, input logic w, input logic [2:0] rn,
                            input logic [2:0] wn, input logic wr, input logic la,
                            input logic lb, input logic lc, input logic ls,
                            input logic as, input logic [1:0] vs);
        chk({tag, ".w"},        {15'd0, bus.w},        {15'd0, w});
        chk({tag, ".readnum"},  {13'd0, bus.readnum},  {13'd0, rn});
        chk({tag, ".writenum"}, {13'd0, bus.writenum}, {13'd0, wn});
        chk({tag, ".write"},    {15'd0, bus.write},    {15'd0, wr});
        chk({tag, ".loada"},    {15'd0, bus.loada},    {15'd0, la});
        chk({tag, ".loadb"},    {15'd0, bus.loadb},    {15'd0, lb});
        chk({tag, ".loadc"},    {15'd0, bus.loadc},    {15'd0, lc});
        chk({tag, ".loads"},    {15'd0, bus.loads},    {15'd0, ls});
        chk({tag, ".asel"},     {15'd0, bus.asel},     {15'd0, as});
        chk({tag, ".bsel"},     {15'd0, bus.bsel},     16'd0);
        chk({tag, ".vsel"},     {14'd0, bus.vsel},     {14'd0, vs});
    endtask

    // Present a word with load and s together for one edge, then drop both
    task automatic start(input logic [15:0] word);
        bus.in   = word;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.s    = 1'b0;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.in   = 16'h0000;
        bus.load = 1'b0;
        bus.s    = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_ctrl("rst", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("rst.sximm8", bus.sximm8, 16'h0000);
        chk("rst.sximm5", bus.sximm5, 16'h0000);
        chk("rst.aluop", {14'd0, bus.ALUop}, 16'd0);

        // MOV R1,#-2 (0xD1FE)
        start(16'hD1FE);
        chk_ctrl("movi.dec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("movi.sximm8", bus.sximm8, 16'hFFFE);
        chk("movi.sximm5", bus.sximm5, 16'hFFFE);
        tick();
        chk_ctrl("movi.wimm", 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        chk_ctrl("movi.done", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // ADD R2,R1,R0,LSL#1 (0xA148) with a mid-instruction load attempt
        start(16'hA148);
        chk_ctrl("add.dec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("add.shift", {14'd0, bus.shift}, 16'd1);
        bus.in   = 16'hFFFF;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_ctrl("add.geta", 1'b0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("add.ir_hold", bus.sximm8, 16'h0048);
        tick();
        chk_ctrl("add.getb", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("add.exec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("add.aluop", {14'd0, bus.ALUop}, 16'd0);
        chk("add.shift2", {14'd0, bus.shift}, 16'd1);
        tick();
        chk_ctrl("add.write", 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("add.done", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // CMP R0,R1 (0xA801)
        start(16'hA801);
        chk_ctrl("cmp.dec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("cmp.geta", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("cmp.getb", 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("cmp.exec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        chk("cmp.aluop", {14'd0, bus.ALUop}, 16'd1);
        tick();
        chk_ctrl("cmp.done", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // MOV R3,R0 (0xC060)
        start(16'hC060);
        chk_ctrl("movr.dec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("movr.getb", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("movr.exec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        chk("movr.aluop", {14'd0, bus.ALUop}, 16'd0);
        tick();
        chk_ctrl("movr.write", 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("movr.done", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Illegal opcode 111 (0xE000): one DECODE cycle, no strobes
        start(16'hE000);
        chk_ctrl("ill.dec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("ill.done", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // MVN R3,R1 (0xB861)
        start(16'hB861);
        tick();
        chk_ctrl("mvn.getb", 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_ctrl("mvn.exec", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("mvn.aluop", {14'd0, bus.ALUop}, 16'd3);
        tick();
        chk_ctrl("mvn.write", 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk("mvn.done.w", {15'd0, bus.w}, 16'd1);

        // ADD again, reset asserted while in GETB
        start(16'hA148);
        tick();
        tick();
        chk("rgetb.loadb_pre", {15'd0, bus.loadb}, 16'd1);
        reset = 1'b1;
        #1;
        chk("rgetb.loadb_gated", {15'd0, bus.loadb}, 16'd0);
        chk("rgetb.write_gated", {15'd0, bus.write}, 16'd0);
        tick();
        reset = 1'b0;
        chk_ctrl("rgetb.after", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("rgetb.ir_clear", bus.sximm8, 16'h0000);
        tick();
        chk_ctrl("rgetb.idle", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
